serial_add_seq: RTL and testbench
=================================

# serial_add_seq

Bit-serial addition sequencer that sits directly upstream of the 1-bit full-adder cell and drives it. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It presents one operand bit pair per cycle, LSB first, to the full adder's `a`/`b`/`cin` inputs and captures the adder's `sum`/`cout` back each cycle. After WIDTH cycles it returns the WIDTH-bit sum and final carry over a second valid/ready handshake.

## Interface

Parameters:
- `WIDTH`, default 8: operand width in bits, legal range ≥ 2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept an operand request.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `in_cin`  in  1  carry-in for bit 0.
- `fa_a`  out  1  bit to full-adder `a`.
- `fa_b`  out  1  bit to full-adder `b`.
- `fa_cin`  out  1  carry to full-adder `cin`.
- `fa_sum`  in  1  full-adder `sum`, combinational from `fa_*`.
- `fa_cout`  in  1  full-adder `cout`, combinational from `fa_*`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  WIDTH  sum, bit i = bit i of A+B+cin.
- `out_cout`  out  1  carry out of bit WIDTH-1.
- `busy`  out  1  state ≠ IDLE.

## Operation

- FSM has three states: IDLE, RUN and DONE.
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, latch `in_a`/`in_b` into the A/B shift registers and `in_cin` into `carry_q`, clear `bit_cnt`, then go to RUN.
  - RUN: `fa_a`=A[0], `fa_b`=B[0], `fa_cin`=`carry_q`. Each cycle:
    - shift A/B right by one;
    - shift `fa_sum` into the MSB of the sum register (right shift);
    - `carry_q` <= `fa_cout`;
    - `bit_cnt`++.
    - When `bit_cnt`==WIDTH-1, go to DONE and capture `out_cout` <= `fa_cout`.
  - DONE: `out_valid`=1. When `out_valid`&&`out_ready`, go to IDLE.
- `fa_a`, `fa_b` and `fa_cin` are driven 0 outside RUN.
- `bit_cnt` width is $clog2(WIDTH). No arithmetic is performed inside the block; all addition happens in the external cell.
- `in_ready` is decoded from state IDLE only. `in_valid` in RUN or DONE is ignored and has no side effect.
- Inputs `in_a`/`in_b`/`in_cin` are sampled only on the accepting edge; later changes have no effect.
- `out_sum`/`out_cout` hold stable from DONE entry until the output handshake completes, and keep their last value in IDLE.

Reset values (`rst`=0, effective immediately, asynchronous):
- State IDLE, so `in_ready`=1.
- `out_valid`=0, `busy`=0.
- `out_sum`=0, `out_cout`=0.
- `fa_a`/`fa_b`/`fa_cin`=0.
- `bit_cnt`=0, `carry_q`=0.

Reset in RUN or DONE aborts the operation and discards the partial result; no output handshake occurs.

## Timing

- Accept at edge k: RUN covers cycles k+1 … k+WIDTH.
- `out_valid` rises after edge k+WIDTH. Latency from accept to result-valid is WIDTH+1 edges.
- Minimum initiation interval is WIDTH+2 cycles: one IDLE cycle, WIDTH RUN cycles, and at least one DONE cycle.
- Combinational path `fa_*` → external cell → `fa_sum`/`fa_cout` → flop D must close within one `clk` period. No other combinational in→out paths exist except `in_ready`/`out_valid`, which come from state flops only.
- Back-to-back handshakes: the DONE→IDLE transition and a new accept cannot share an edge.

## Structure

- Package `serial_add_pkg` holds:
  - typedef `sa_state_e` {IDLE, RUN, DONE};
  - constant `SA_DEFAULT_WIDTH` = 8.
- The full-adder cell stays external and is not instantiated inside this block; the top level wires `fa_*`.
- One natural sub-module is `serial_add_shreg`, holding the A/B/sum shift registers with load and shift enables. The FSM, counter and `carry_q` stay in `serial_add_seq`.

## Test plan

Bench: WIDTH=8, with a behavioural full adder connected to the `fa_*` ports.

- 0x5A + 0x33, cin 0 → `out_sum`=0x8D, `out_cout`=0; `out_valid` 9 edges after accept.
- 0xFF + 0x01, cin 0 → `out_sum`=0x00, `out_cout`=1. 0xFF + 0xFF, cin 1 → `out_sum`=0xFF, `out_cout`=1.
- Port sequence check, 0x01 + 0x80, cin 1:
  - `fa_a` = 1,0,0,0,0,0,0,0 and `fa_b` = 0,0,0,0,0,0,0,1 over the 8 RUN cycles;
  - first `fa_cin`=1;
  - result 0x82, cout 0.
- Backpressure: `out_ready`=0 for 5 cycles in DONE → `out_valid`, `out_sum` and `out_cout` held; `in_ready`=0 and `in_valid` pulses ignored; release → IDLE next edge.
- Reset pulse during RUN bit 3 → all outputs go to their reset values immediately, no `out_valid`. The next op, 0x10 + 0x20, cin 0, → 0x30, cout 0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module   : serial_add_pkg
// Brief    : Shared types and constants for the bit-serial add sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int SA_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage : serial_add_pkg

`default_nettype wire

// File: rtl/serial_add_shreg.sv
// ============================================================================
// Module   : serial_add_shreg
// Brief    : Operand A/B and sum shift registers for the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sum_bit_i,
    output logic             a_lsb_o,
    output logic             b_lsb_o,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        if (load_i) begin
            a_d = a_i;
            b_d = b_i;
        end else if (shift_i) begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            // Sum bits arrive LSB first, so after WIDTH shifts bit 0 sits at bit 0.
            sum_d = {sum_bit_i, sum_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
        end
    end

    assign a_lsb_o = a_q[0];
    assign b_lsb_o = b_q[0];
    assign sum_o   = sum_q;

endmodule : serial_add_shreg

`default_nettype wire

// File: rtl/serial_add_seq.sv
// ============================================================================
// Module   : serial_add_seq
// Brief    : Sequences an external 1-bit full adder through a WIDTH-bit add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_e         state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              carry_q;
    logic              out_cout_q;

    logic              w_load;
    logic              w_shift;
    logic              w_a_lsb;
    logic              w_b_lsb;

    assign w_load  = (state_q == IDLE) && in_valid;
    assign w_shift = (state_q == RUN);

    serial_add_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (w_load),
        .shift_i   (w_shift),
        .a_i       (in_a),
        .b_i       (in_b),
        .sum_bit_i (fa_sum),
        .a_lsb_o   (w_a_lsb),
        .b_lsb_o   (w_b_lsb),
        .sum_o     (out_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            carry_q    <= 1'b0;
            out_cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        carry_q   <= in_cin;
                        bit_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    carry_q   <= fa_cout;
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        out_cout_q <= fa_cout;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Adder inputs are forced low outside RUN so the cell sees no stale operands.
    assign fa_a      = w_shift & w_a_lsb;
    assign fa_b      = w_shift & w_b_lsb;
    assign fa_cin    = w_shift & carry_q;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_cout  = out_cout_q;

endmodule : serial_add_seq

`default_nettype wire

// File: tb/tb_serial_add_seq.sv
// ============================================================================
// Module   : tb_serial_add_seq
// Brief    : Scoreboard bench for serial_add_seq with a behavioural full adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    serial_add_seq #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin);
        logic [WIDTH:0] s;
        exp_t           e;
        s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        return e;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_in_ready"},  in_ready,  1);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_busy"},      busy,      0);
        check({pfx, "_out_sum"},   out_sum,   0);
        check({pfx, "_out_cout"},  out_cout,  0);
        check({pfx, "_fa_bits"},   {fa_a, fa_b, fa_cin}, 0);
    endtask

    // One full transaction; hold > 0 keeps out_ready low for that many DONE cycles.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input int hold);
        logic [WIDTH-1:0] aseq;
        logic [WIDTH-1:0] bseq;
        logic             cin0;
        int               lat;
        bit               got;
        exp_t             e;
        aseq = '0;
        bseq = '0;
        cin0 = 1'b0;
        got  = 1'b0;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        sb.push_back(model(a, b, cin));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = WIDTH'($urandom);
        in_b     = WIDTH'($urandom);
        in_cin   = 1'($urandom);
        lat      = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            if (i < WIDTH) begin
                aseq[i] = fa_a;
                bseq[i] = fa_b;
                if (i == 0) cin0 = fa_cin;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("latency_edges", lat, WIDTH + 1);
        check("fa_a_seq", aseq, a);
        check("fa_b_seq", bseq, b);
        check("fa_cin_first", cin0, cin);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_sum",   out_sum,   e.sum);
            check("bp_out_cout",  out_cout,  e.cout);
            check("bp_in_ready",  in_ready,  0);
            in_valid = h[0];
            in_a     = WIDTH'($urandom);
            in_b     = WIDTH'($urandom);
            in_cin   = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        check("out_valid", out_valid, 1);
        check("out_sum",   out_sum,   e.sum);
        check("out_cout",  out_cout,  e.cout);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready",  in_ready,  1);
        check("post_hs_sum_held",  out_sum,   e.sum);
        check("post_hs_cout_held", out_cout,  e.cout);
    endtask

    task automatic reset_during_run();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_cin   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_busy",    busy, 1);
        check("pre_rst_fa_bits", {fa_a, fa_b, fa_cin}, 3'b111);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_valid_after_abort", seen, 0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op(8'h5A, 8'h33, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 0);
        do_op(8'hFF, 8'hFF, 1'b1, 0);
        do_op(8'h01, 8'h80, 1'b1, 0);
        do_op(8'hA5, 8'h3C, 1'b1, 5);
        reset_during_run();
        do_op(8'h10, 8'h20, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_add_seq

`default_nettype wire
